// File: rtl/axilite_q_master.sv
// axilite_q_master: AXI4-Lite master fed by a command FIFO,
// with a decoupled response port and saturating error counter.
module axilite_q_master #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int CMD_DEPTH = 4,
  parameter int ERR_W     = 8
) (
  input  logic                aclk,
  input  logic                aresetn,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [2:0]          m_axi_awprot,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [2:0]          m_axi_arprot,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_w_r,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_data,
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_w_r,
  output logic [DATA_W-1:0]   rsp_data,
  output logic [1:0]          rsp_resp,
  output logic                busy,
  output logic [ERR_W-1:0]    err_count
);
  localparam int SW = DATA_W / 8;
  localparam int PW = $clog2(CMD_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic              w_r;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [SW-1:0]     strb;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE, ISSUE, WRESP, RRESP
  } state_t;

  cmd_t          mem_q [CMD_DEPTH];
  cmd_t          new_cmd;
  logic [PW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic          full, empty, push, pop;
  state_t        state_q, state_d;
  cmd_t          cur_q, cur_d;
  logic          awv_q, awv_d, wv_q, wv_d;
  logic          arv_q, arv_d;
  logic          rv_q, rv_d, rw_q, rw_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic [1:0]    rr_q, rr_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic          rsp_free, b_hs, r_hs;

  assign full      = cnt_q == CW'(CMD_DEPTH);
  assign empty     = cnt_q == '0;
  assign cmd_ready = ~full;
  assign push      = cmd_valid & ~full;

  assign new_cmd.w_r  = cmd_w_r;
  assign new_cmd.addr = cmd_addr;
  assign new_cmd.data = cmd_w_r ? '0 : cmd_data;
  assign new_cmd.strb = cmd_w_r ? '0 : cmd_strb;

  // A held response blocks B/R until the consumer drains it
  assign rsp_free     = ~rv_q | rsp_ready;
  assign m_axi_bready = (state_q == WRESP) & rsp_free;
  assign m_axi_rready = (state_q == RRESP) & rsp_free;
  assign b_hs = m_axi_bready & m_axi_bvalid;
  assign r_hs = m_axi_rready & m_axi_rvalid;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    awv_d   = awv_q;
    wv_d    = wv_q;
    arv_d   = arv_q;
    rv_d    = rv_q & ~rsp_ready;
    rw_d    = rw_q;
    rd_d    = rd_q;
    rr_d    = rr_q;
    err_d   = err_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: pop = ~empty;
      ISSUE: begin
        if (cur_q.w_r) begin
          arv_d = arv_q & ~m_axi_arready;
          if (arv_q & m_axi_arready) state_d = RRESP;
        end else begin
          awv_d = awv_q & ~m_axi_awready;
          wv_d  = wv_q & ~m_axi_wready;
          if (~awv_d & ~wv_d) state_d = WRESP;
        end
      end
      WRESP, RRESP: begin
        if (b_hs | r_hs) begin
          rv_d    = 1'b1;
          rw_d    = r_hs;
          rd_d    = r_hs ? m_axi_rdata : '0;
          rr_d    = r_hs ? m_axi_rresp : m_axi_bresp;
          if (rr_d[1] && err_q != '1) err_d = err_q + 1'b1;
          pop     = ~empty;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      cur_d   = mem_q[rp_q];
      awv_d   = ~cur_d.w_r;
      wv_d    = ~cur_d.w_r;
      arv_d   = cur_d.w_r;
      state_d = ISSUE;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      cur_q   <= '0;
      awv_q   <= 1'b0;
      wv_q    <= 1'b0;
      arv_q   <= 1'b0;
      rv_q    <= 1'b0;
      rw_q    <= 1'b0;
      rd_q    <= '0;
      rr_q    <= '0;
      err_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      awv_q   <= awv_d;
      wv_q    <= wv_d;
      arv_q   <= arv_d;
      rv_q    <= rv_d;
      rw_q    <= rw_d;
      rd_q    <= rd_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
      if (push) wp_q <= wp_q + 1'b1;
      if (pop)  rp_q <= rp_q + 1'b1;
      cnt_q   <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge aclk) begin
    if (push) mem_q[wp_q] <= new_cmd;
  end

  assign m_axi_awvalid = awv_q;
  assign m_axi_wvalid  = wv_q;
  assign m_axi_arvalid = arv_q;
  assign m_axi_awaddr  = awv_q ? cur_q.addr : '0;
  assign m_axi_wdata   = wv_q ? cur_q.data : '0;
  assign m_axi_wstrb   = wv_q ? cur_q.strb : '0;
  assign m_axi_araddr  = arv_q ? cur_q.addr : '0;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_arprot  = 3'b000;

  assign rsp_valid = rv_q;
  assign rsp_w_r   = rw_q;
  assign rsp_data  = rd_q;
  assign rsp_resp  = rr_q;
  assign err_count = err_q;
  assign busy      = ~empty | (state_q != IDLE);

endmodule

// File: tb/tb_axilite_q_master.sv
// tb_axilite_q_master: directed and random checks of the queued
// AXI4-Lite master against a transaction-level reference model.
module tb_axilite_q_master;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int SW = 8;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
  logic [2:0]    m_axi_awprot, m_axi_arprot;
  logic          m_axi_awvalid, m_axi_awready;
  logic [DW-1:0] m_axi_wdata;
  logic [SW-1:0] m_axi_wstrb;
  logic          m_axi_wvalid, m_axi_wready;
  logic [1:0]    m_axi_bresp;
  logic          m_axi_bvalid, m_axi_bready;
  logic          m_axi_arvalid, m_axi_arready;
  logic [DW-1:0] m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rvalid, m_axi_rready;
  logic          cmd_valid, cmd_ready, cmd_w_r;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic [SW-1:0] cmd_strb;
  logic          rsp_valid, rsp_ready, rsp_w_r;
  logic [DW-1:0] rsp_data;
  logic [1:0]    rsp_resp;
  logic          busy;
  logic [7:0]    err_count;

  always #5 aclk = ~aclk;

  axilite_q_master #(
    .ADDR_W(AW), .DATA_W(DW), .CMD_DEPTH(4), .ERR_W(8)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_w_r(cmd_w_r),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_w_r(rsp_w_r),
    .rsp_data(rsp_data), .rsp_resp(rsp_resp),
    .busy(busy), .err_count(err_count)
  );

  typedef struct {
    logic          w_r;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
  } tcmd_t;

  typedef struct {
    logic          w_r;
    logic [DW-1:0] data;
    logic [1:0]    resp;
  } trsp_t;

  int checks = 0;
  int errors = 0;
  tcmd_t exp_aw[$], exp_w[$], exp_ar[$];
  trsp_t exp_rsp[$];
  logic [AW-1:0] s_aw[$], s_ar[$];
  int s_w_cnt = 0;
  int n_b = 0, n_rsp = 0, model_err = 0;
  // ready/valid knobs: 0 random, 1 always, 2 never
  int aw_mode = 1, w_mode = 1, ar_mode = 1, rsp_mode = 1, b_mode = 1;
  bit cmd_pend = 0, cmd_acc = 0, b_done = 0, r_done = 0;
  tcmd_t cmd_cur;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input int m);
    if (m == 1) return 1'b1;
    if (m == 2) return 1'b0;
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] a);
    if (a == 32'h20) return 64'hDEAD_BEEF;
    return {a, ~a};
  endfunction

  function automatic logic [1:0] resp_fn(input logic [AW-1:0] a);
    return a[3:2];
  endfunction

  task automatic tick();
    trsp_t e;
    logic  ok;
    @(negedge aclk);
    if (b_done) begin m_axi_bvalid = 1'b0; b_done = 0; end
    if (r_done) begin m_axi_rvalid = 1'b0; r_done = 0; end
    m_axi_awready = rdy(aw_mode);
    m_axi_wready  = rdy(w_mode);
    m_axi_arready = rdy(ar_mode);
    rsp_ready     = rdy(rsp_mode);
    if (!m_axi_bvalid && s_aw.size() > 0 && s_w_cnt > 0
        && rdy(b_mode)) begin
      m_axi_bvalid = 1'b1;
      m_axi_bresp  = resp_fn(s_aw.pop_front());
      s_w_cnt--;
    end
    if (!m_axi_rvalid && s_ar.size() > 0 && rdy(b_mode)) begin
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = rd_fn(s_ar[0]);
      m_axi_rresp  = resp_fn(s_ar.pop_front());
    end
    cmd_valid = cmd_pend;
    cmd_w_r   = cmd_cur.w_r;
    cmd_addr  = cmd_cur.addr;
    cmd_data  = cmd_cur.data;
    cmd_strb  = cmd_cur.strb;
    #1;
    ok = (m_axi_awvalid || m_axi_awaddr == '0)
      && (m_axi_wvalid || (m_axi_wdata == '0 && m_axi_wstrb == '0))
      && (m_axi_arvalid || m_axi_araddr == '0)
      && m_axi_awprot == 3'b000 && m_axi_arprot == 3'b000;
    chk("chan_zero", ok, 1'b1);
    cmd_acc = cmd_valid && cmd_ready;
    if (cmd_acc) begin
      cmd_pend = 0;
      if (cmd_cur.w_r) exp_ar.push_back(cmd_cur);
      else begin
        exp_aw.push_back(cmd_cur);
        exp_w.push_back(cmd_cur);
      end
      e.w_r  = cmd_cur.w_r;
      e.data = cmd_cur.w_r ? rd_fn(cmd_cur.addr) : '0;
      e.resp = resp_fn(cmd_cur.addr);
      exp_rsp.push_back(e);
    end
    if (m_axi_awvalid && m_axi_awready) begin
      chk("aw_pending", exp_aw.size() != 0, 1'b1);
      if (exp_aw.size() != 0) begin
        chk("aw_addr", m_axi_awaddr, exp_aw[0].addr);
        void'(exp_aw.pop_front());
        s_aw.push_back(m_axi_awaddr);
      end
    end
    if (m_axi_wvalid && m_axi_wready) begin
      chk("w_pending", exp_w.size() != 0, 1'b1);
      if (exp_w.size() != 0) begin
        chk("w_data", {m_axi_wstrb, m_axi_wdata},
            {exp_w[0].strb, exp_w[0].data});
        void'(exp_w.pop_front());
        s_w_cnt++;
      end
    end
    if (m_axi_arvalid && m_axi_arready) begin
      chk("ar_pending", exp_ar.size() != 0, 1'b1);
      if (exp_ar.size() != 0) begin
        chk("ar_addr", m_axi_araddr, exp_ar[0].addr);
        void'(exp_ar.pop_front());
        s_ar.push_back(m_axi_araddr);
      end
    end
    if (m_axi_bvalid && m_axi_bready) begin b_done = 1; n_b++; end
    if (m_axi_rvalid && m_axi_rready) r_done = 1;
    if (rsp_valid && rsp_ready) begin
      chk("rsp_pending", exp_rsp.size() != 0, 1'b1);
      if (exp_rsp.size() != 0) begin
        e = exp_rsp.pop_front();
        chk("rsp", {rsp_w_r, rsp_data, rsp_resp},
            {e.w_r, e.data, e.resp});
        if (e.resp[1] && model_err < 255) model_err++;
        chk("err_count", err_count, model_err);
        n_rsp++;
      end
    end
  endtask

  task automatic push_cmd(input logic w_r, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [SW-1:0] s);
    int n;
    cmd_cur.w_r  = w_r;
    cmd_cur.addr = a;
    cmd_cur.data = d;
    cmd_cur.strb = s;
    cmd_pend = 1;
    n = 0;
    while (cmd_pend && n < 500) begin tick(); n++; end
    chk("push_timeout", cmd_pend, 1'b0);
    cmd_pend = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin tick(); n++; end
    while ((exp_rsp.size() != 0 || busy || rsp_valid) && n < 4000);
    chk("drain_left", exp_rsp.size(), 0);
    chk("drain_busy", busy, 1'b0);
  endtask

  task automatic check_reset();
    chk("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                       m_axi_bready, m_axi_rready}, 5'b0);
    chk("rst_addr", {m_axi_awaddr, m_axi_araddr}, 64'h0);
    chk("rst_wdata", {m_axi_wstrb, m_axi_wdata}, 72'h0);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_rsp", {rsp_valid, rsp_w_r, rsp_data, rsp_resp}, 68'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err_count, 8'h0);
  endtask

  initial begin
    int nb, nr;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
    m_axi_bvalid = 0; m_axi_bresp = 0;
    m_axi_rvalid = 0; m_axi_rresp = 0; m_axi_rdata = 0;
    cmd_valid = 0; cmd_w_r = 0; cmd_addr = 0; cmd_data = 0; cmd_strb = 0;
    rsp_ready = 0;
    cmd_cur = '{1'b0, '0, '0, '0};

    // reset state
    tick(); tick();
    check_reset();
    aresetn = 1'b1;
    tick();

    // single write, always-ready slave: timing of issue and response
    push_cmd(1'b0, 32'h10, 64'h1122_3344_5566_7788, 8'hFF);
    tick();
    chk("t1_no_early_aw", m_axi_awvalid, 1'b0);
    tick();
    chk("t1_aw_w_valid", {m_axi_awvalid, m_axi_wvalid}, 2'b11);
    chk("t1_awaddr", m_axi_awaddr, 32'h10);
    tick();
    chk("t1_aw_dropped", {m_axi_awvalid, m_axi_wvalid}, 2'b00);
    chk("t1_bready", {m_axi_bvalid, m_axi_bready, rsp_valid}, 3'b110);
    tick();
    chk("t1_rsp", {rsp_valid, rsp_w_r, rsp_resp}, 4'b1000);
    drain();

    // wready two cycles ahead of awready
    nb = n_b; nr = n_rsp;
    aw_mode = 2;
    push_cmd(1'b0, 32'h30, 64'hA5A5_0000_FFFF_1234, 8'h0F);
    tick(); tick();
    tick();
    chk("t2_w_first", {m_axi_awvalid, m_axi_wvalid}, 2'b10);
    tick();
    chk("t2_aw_held", {m_axi_awvalid, m_axi_wvalid}, 2'b10);
    aw_mode = 1;
    drain();
    chk("t2_one_b", n_b - nb, 1);
    chk("t2_one_rsp", n_rsp - nr, 1);

    // held response blocks the next R
    rsp_mode = 2;
    push_cmd(1'b1, 32'h20, 64'h0, 8'h0);
    push_cmd(1'b1, 32'h24, 64'h0, 8'h0);
    for (int i = 0; i < 30 && !rsp_valid; i++) tick();
    chk("t3_rsp_seen", rsp_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold", {rsp_valid, rsp_w_r, rsp_data},
          {2'b11, 64'hDEAD_BEEF});
    end
    chk("t3_r_stalled", {m_axi_rvalid, m_axi_rready}, 2'b10);
    rsp_mode = 1;
    drain();

    // fill the FIFO behind a stalled AW
    aw_mode = 2;
    for (int i = 0; i < 5; i++)
      push_cmd(1'b0, 32'h100 + 32'(i * 16), {32'(i), 32'hC0DE}, 8'hFF);
    tick();
    chk("t4_full", cmd_ready, 1'b0);
    cmd_cur = '{1'b1, 32'h200, '0, '0};
    cmd_pend = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_blocked", {cmd_ready, cmd_acc}, 2'b00);
    end
    aw_mode = 1;
    for (int i = 0; i < 100 && cmd_pend; i++) tick();
    chk("t4_sixth_in", cmd_pend, 1'b0);
    drain();

    // SLVERR saturation
    for (int i = 0; i < 300; i++)
      push_cmd(1'b0, 32'h1000 + 32'(i * 16) + 32'h8, 64'(i), 8'h01);
    drain();
    chk("t5_sat", err_count, 8'd255);
    push_cmd(1'b0, 32'h40, 64'h1, 8'h1);
    drain();
    chk("t5_okay_hold", err_count, 8'd255);

    // randomized traffic with random stalls everywhere
    aw_mode = 0; w_mode = 0; ar_mode = 0; rsp_mode = 0; b_mode = 0;
    for (int i = 0; i < 150; i++)
      push_cmd(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC,
               {$urandom, $urandom}, 8'($urandom_range(0, 255)));
    drain();
    aw_mode = 1; w_mode = 1; ar_mode = 1; rsp_mode = 1;

    // reset in WRESP with two commands queued
    b_mode = 2;
    for (int i = 0; i < 3; i++)
      push_cmd(1'b0, 32'h300 + 32'(i * 16), 64'hBAD, 8'h3);
    tick(); tick();
    chk("t6_in_wresp", {busy, m_axi_awvalid, m_axi_bready}, 3'b101);
    @(negedge aclk);
    aresetn = 1'b0;
    m_axi_bvalid = 0; m_axi_rvalid = 0; b_done = 0; r_done = 0;
    exp_aw.delete(); exp_w.delete(); exp_ar.delete(); exp_rsp.delete();
    s_aw.delete(); s_ar.delete(); s_w_cnt = 0; model_err = 0;
    b_mode = 1;
    #1;
    check_reset();
    tick(); tick();
    aresetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_quiet", {busy, rsp_valid, m_axi_awvalid}, 3'b000);
    end
    push_cmd(1'b1, 32'h20, 64'h0, 8'h0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axilite_q_master.md
# axilite_q_master

AXI4-Lite master with a parametrised command queue and a decoupled response port. It generalises the single-shot user-start master: commands are buffered in a FIFO of depth `CMD_DEPTH`, and AW and W are issued concurrently with independent handshakes. Responses return through a valid/ready port with backpressure onto B/R, and a saturating error counter tracks failed responses. It sits between a local control engine and one AXI4-Lite slave port of the interconnect.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 64: data width; multiple of 8.
- `CMD_DEPTH`, 4: command FIFO entries; power of 2, ≥2.
- `ERR_W`, 8: error counter width.

Ports:
- `aclk`  in  1  clock; all logic on rising edge.
- `aresetn`  in  1  reset, asynchronous assert, active-low.
- `m_axi_awaddr/awprot/awvalid/awready`  out/out/out/in  ADDR_W/3/1/1  AW channel.
- `m_axi_wdata/wstrb/wvalid/wready`  out/out/out/in  DATA_W/DATA_W/8/1/1  W channel.
- `m_axi_bresp/bvalid/bready`  in/in/out  2/1/1  B channel.
- `m_axi_araddr/arprot/arvalid/arready`  out/out/out/in  ADDR_W/3/1/1  AR channel.
- `m_axi_rdata/rresp/rvalid/rready`  in/in/in/out  DATA_W/2/1/1  R channel.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  FIFO not full.
- `cmd_w_r`  in  1  0 = write, 1 = read.
- `cmd_addr`  in  ADDR_W  target address.
- `cmd_data`, `cmd_strb`  in  DATA_W, DATA_W/8  write payload; stored as 0 for reads.
- `rsp_valid`  out  1  response held.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_w_r`  out  1  type of completed command.
- `rsp_data`  out  DATA_W  read data; 0 for writes.
- `rsp_resp`  out  2  BRESP/RRESP.
- `busy`  out  1  FIFO non-empty or FSM not IDLE.
- `err_count`  out  ERR_W  saturating count of responses with resp[1]=1.

## Operation
- Push on `cmd_valid & cmd_ready`. `cmd_ready = ~full` is registered-derived and does not depend on a same-cycle pop. Full and empty come from a (log2 CMD_DEPTH + 1)-bit count.
- FSM states: IDLE, ISSUE, WRESP, RRESP.
- IDLE: if the FIFO is non-empty, pop the head into the issue registers, go to ISSUE, and raise awvalid+wvalid (write) or arvalid (read) at that edge.
- ISSUE, write: awvalid and wvalid each drop on the edge of their own handshake. Go to WRESP on the edge where both are done, including both on the same edge or either order.
- ISSUE, read: hold arvalid until arready, then go to RRESP.
- WRESP/RRESP: `bready`/`rready` = state match & (~rsp_valid | rsp_ready), combinational.
- On a B/R handshake: load the rsp_* registers, set rsp_valid, and increment err_count if resp[1] is set, saturating at all-ones. Then pop and go to ISSUE if the FIFO is non-empty, else go to IDLE.
- rsp_valid clears on `rsp_valid & rsp_ready` unless a new response loads on the same edge, in which case it stays 1 with the new contents.
- AXI address/data/strb outputs are 0 whenever their valid is low. awprot and arprot are constant 3'b000.
- Only one AXI transaction is outstanding at a time. Commands complete in FIFO order.

## Timing
- Reset values: all valids 0, all address/data/strb 0, bready/rready 0, cmd_ready 1, rsp_* 0, busy 0, err_count 0, FIFO empty, state IDLE.
- Reset mid-transaction drops the FIFO and the in-flight command immediately. No response is generated.
- Command accepted on edge E0 → awvalid/arvalid high after E1 (one-cycle FIFO latency).
- When the slave is always ready, a write takes: E1 issue, E2 handshake, E3 B accepted.
- rsp_valid rises the cycle after the B/R handshake.
- Back-to-back commands: the next issue starts on the same edge as the B/R handshake. There are no idle bubbles.
- A stalled rsp_ready holds bready/rready low and the FSM waits in WRESP/RRESP. The FIFO keeps accepting until full.
- Push on an empty FIFO and pop happen no earlier than the next edge. A simultaneous push and pop leaves the count unchanged.

## Test plan
- Write addr 0x10, data 0x1122334455667788, strb 0xFF, awready=wready=1 → AW/W valid one cycle; rsp_valid with rsp_w_r=0, rsp_resp=00 three edges after accept.
- Write with wready asserted 2 cycles before awready → wvalid drops first, awvalid is held; single B accepted; exactly one rsp.
- Read addr 0x20, rdata 0xDEADBEEF, rsp_ready=0 for 5 cycles → rsp_data=0xDEADBEEF is held. A second queued read's R stays unaccepted (rready=0) until rsp_ready=1.
- Push 5 commands with awready=0 and CMD_DEPTH=4 → cmd_ready low after the 4th FIFO entry; all 5 complete in order once awready=1.
- 300 writes answered with bresp=10, ERR_W=8 → err_count saturates at 255. An OKAY response does not change it.
- aresetn low while in WRESP with 2 queued commands → all outputs at reset values; after release busy=0 and no stale rsp.
